// File: rtl/syn_gpu_pkg.sv
// syn_gpu_pkg: shared types for the syn_gpu mulberry engine arbiter.
//   tgt_e     - request target encoding (DIV/MUL/RAND/INV), 2 bits
//   NUM_ENG   - number of shared engines
//   eng_st_e  - per-engine occupancy state
package syn_gpu_pkg;
  typedef enum logic [1:0] {
    TGT_DIV  = 2'd0,
    TGT_MUL  = 2'd1,
    TGT_RAND = 2'd2,
    TGT_INV  = 2'd3
  } tgt_e;

  localparam int NUM_ENG = 3;

  typedef enum logic {
    ENG_IDLE = 1'b0,
    ENG_BUSY = 1'b1
  } eng_st_e;
endpackage

// File: rtl/syn_rr_arb.sv
// syn_rr_arb: combinational round-robin picker.
//   req - request vector
//   ptr - index with highest priority this cycle
//   gnt - one-hot grant (first set req at or after ptr, wrapping)
//   vld - any request granted
module syn_rr_arb #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);
  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/syn_gpu_mulbry_arb.sv
// syn_gpu_mulbry_arb: round-robin scheduler sharing the DIV/MUL/RAND mulberry
// engines among NUM_REQ core job requesters. One grant per cycle; each engine
// holds at most one transaction and remembers its owner for response routing.
//   clk_ir, rst_sync_l          - clock, async active-low reset
//   req_vld/req_tgt/req_data0/1 - per-requester request (held until req_gnt)
//   req_gnt                     - one-cycle grant pulse
//   rsp_vld/rsp_data/rsp_err    - per-requester response (data/err held)
//   slv_vld/slv_data0/1         - one-hot engine issue strobe + shared operands
//   slv_rsp_vld/slv_rsp_data    - engine result strobes + results
// Optional: SYN_GPU_MULBRY_ARB_TIMEOUT_EN adds a per-engine watchdog that
// retires a BUSY engine after TIMEOUT_CYC cycles with rsp_err=1.
module syn_gpu_mulbry_arb
  import syn_gpu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk_ir,
  input  logic                        rst_sync_l,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [2*NUM_REQ-1:0]        req_tgt,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data0,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data1,
  output logic [NUM_REQ-1:0]          req_gnt,
  output logic [NUM_REQ-1:0]          rsp_vld,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
  output logic [NUM_REQ-1:0]          rsp_err,
  output logic [NUM_ENG-1:0]          slv_vld,
  output logic [DATA_W-1:0]           slv_data0,
  output logic [DATA_W-1:0]           slv_data1,
  input  logic [NUM_ENG-1:0]          slv_rsp_vld,
  input  logic [NUM_ENG*DATA_W-1:0]   slv_rsp_data
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int DW = DATA_W;

  eng_st_e       eng_st  [NUM_ENG];
  logic [PW-1:0] eng_own [NUM_ENG];
  logic [NUM_REQ-1:0] outst;     // requester has a transaction in flight
  logic [NUM_REQ-1:0] inv_pend;  // invalid-target grant awaiting its error reply
  logic [PW-1:0] rr_ptr;

  logic [NUM_REQ-1:0] elig, pick;
  logic               pick_vld, eng_free;
  logic [PW-1:0]      win;
  logic [1:0]         win_tgt;
  logic [DW-1:0]      win_d0, win_d1;

`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] eng_cnt [NUM_ENG];
`else
  // Watchdog not built; keep the parameter referenced for a uniform interface.
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYC;
`endif

  // Engine state is registered, so an engine answering this cycle still reads
  // BUSY here and cannot be re-won until the next cycle.
  always_comb begin
    elig     = '0;
    eng_free = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eng_free = (req_tgt[2*i +: 2] == TGT_INV);
      for (int e = 0; e < NUM_ENG; e++)
        if (req_tgt[2*i +: 2] == 2'(e) && eng_st[e] == ENG_IDLE) eng_free = 1'b1;
      elig[i] = req_vld[i] && !outst[i] && eng_free;
    end
  end

  syn_rr_arb #(.N(NUM_REQ)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick),
    .vld (pick_vld)
  );

  always_comb begin
    win     = '0;
    win_tgt = '0;
    win_d0  = '0;
    win_d1  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) begin
        win     = PW'(i);
        win_tgt = req_tgt[2*i +: 2];
        win_d0  = req_data0[i*DW +: DW];
        win_d1  = req_data1[i*DW +: DW];
      end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      rr_ptr    <= '0;
      outst     <= '0;
      inv_pend  <= '0;
      req_gnt   <= '0;
      rsp_vld   <= '0;
      rsp_data  <= '0;
      rsp_err   <= '0;
      slv_vld   <= '0;
      slv_data0 <= '0;
      slv_data1 <= '0;
      for (int e = 0; e < NUM_ENG; e++) begin
        eng_st[e]  <= ENG_IDLE;
        eng_own[e] <= '0;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
        eng_cnt[e] <= '0;
`endif
      end
    end else begin
      req_gnt  <= '0;
      rsp_vld  <= '0;
      slv_vld  <= '0;
      inv_pend <= '0;

      // Invalid-target grants complete one cycle after their grant pulse.
      for (int i = 0; i < NUM_REQ; i++)
        if (inv_pend[i]) begin
          rsp_vld[i]            <= 1'b1;
          rsp_err[i]            <= 1'b1;
          rsp_data[i*DW +: DW]  <= '0;
          outst[i]              <= 1'b0;
        end

      // Engine completions; owners are distinct so all can land together.
      for (int e = 0; e < NUM_ENG; e++)
        if (eng_st[e] == ENG_BUSY) begin
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
          eng_cnt[e] <= eng_cnt[e] + 1'b1;
`endif
          if (slv_rsp_vld[e]) begin
            rsp_vld[eng_own[e]]                   <= 1'b1;
            rsp_err[eng_own[e]]                   <= 1'b0;
            rsp_data[int'(eng_own[e])*DW +: DW]   <= slv_rsp_data[e*DW +: DW];
            outst[eng_own[e]]                     <= 1'b0;
            eng_st[e]                             <= ENG_IDLE;
          end
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
          // A genuine response in the same cycle takes precedence.
          else if (eng_cnt[e] == CW'(TIMEOUT_CYC)) begin
            rsp_vld[eng_own[e]]                   <= 1'b1;
            rsp_err[eng_own[e]]                   <= 1'b1;
            rsp_data[int'(eng_own[e])*DW +: DW]   <= '0;
            outst[eng_own[e]]                     <= 1'b0;
            eng_st[e]                             <= ENG_IDLE;
          end
`endif
        end

      if (pick_vld) begin
        rr_ptr       <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        outst[win]   <= 1'b1;
        req_gnt[win] <= 1'b1;
        if (win_tgt == TGT_INV) inv_pend[win] <= 1'b1;
        for (int e = 0; e < NUM_ENG; e++)
          if (win_tgt == 2'(e)) begin
            eng_st[e]  <= ENG_BUSY;
            eng_own[e] <= win;
            slv_vld[e] <= 1'b1;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
            eng_cnt[e] <= '0;
`endif
          end
        if (win_tgt != TGT_INV) begin
          slv_data0 <= win_d0;
          slv_data1 <= win_d1;
        end
      end
    end
  end
endmodule

// File: tb/tb_syn_gpu_mulbry_arb.sv
// tb_syn_gpu_mulbry_arb: directed self-checking bench for syn_gpu_mulbry_arb.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_syn_gpu_mulbry_arb;
  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk_ir, rst_sync_l;
  logic [NR-1:0]   req_vld;
  logic [2*NR-1:0] req_tgt;
  logic [NR*DW-1:0] req_data0, req_data1;
  logic [NR-1:0]   req_gnt, rsp_vld, rsp_err;
  logic [NR*DW-1:0] rsp_data;
  logic [2:0]      slv_vld, slv_rsp_vld;
  logic [DW-1:0]   slv_data0, slv_data1;
  logic [3*DW-1:0] slv_rsp_data;

  int checks = 0;
  int errors = 0;

  syn_gpu_mulbry_arb #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
    .req_vld(req_vld), .req_tgt(req_tgt),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .slv_vld(slv_vld), .slv_data0(slv_data0), .slv_data1(slv_data1),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_data(slv_rsp_data)
  );

  initial begin
    clk_ir = 1'b0;
    forever #5 clk_ir = ~clk_ir;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] t, input logic [31:0] d0, input logic [31:0] d1);
    req_vld[i]          = 1'b1;
    req_tgt[2*i +: 2]   = t;
    req_data0[i*DW +: DW] = d0;
    req_data1[i*DW +: DW] = d1;
  endtask

  function automatic logic [31:0] rd(input int i);
    return rsp_data[i*DW +: DW];
  endfunction

  int exp_ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_sync_l   = 1'b0;
    req_vld      = '0;
    req_tgt      = '0;
    req_data0    = '0;
    req_data1    = '0;
    slv_rsp_vld  = '0;
    slv_rsp_data = '0;
    tick(); tick();
    chk("rst_gnt", req_gnt, 0);
    chk("rst_slv", slv_vld, 0);
    chk("rst_rsp", rsp_vld, 0);
    rst_sync_l = 1'b1;
    tick();

    // Fairness: all four requesters hammer DIV; DIV answers 2 cycles after issue.
    for (int i = 0; i < NR; i++) set_req(i, 2'd0, 32'(i), 32'(i + 10));
    for (int g = 0; g < 5; g++) begin
      int n;
      n = 0;
      while (!slv_vld[0] && n < 20) begin tick(); n++; end
      chk("fair_wait", 64'(n < 20), 1);
      chk("fair_gnt", req_gnt, 64'(1) << exp_ord[g]);
      chk("fair_d0", slv_data0, 64'(exp_ord[g]));
      tick(); chk("fair_busy1", slv_vld[0], 0);
      tick(); chk("fair_busy2", slv_vld[0], 0);
      slv_rsp_vld = 3'b001;
      slv_rsp_data[31:0] = 32'h100 + 32'(g);
      tick();
      slv_rsp_vld = '0;
      chk("fair_busy3", slv_vld[0], 0);
      chk("fair_rsp", rsp_vld, 64'(1) << exp_ord[g]);
      chk("fair_rdata", rd(exp_ord[g]), 64'h100 + 64'(g));
      chk("fair_err", rsp_err, 0);
    end
    req_vld = '0;
    tick();

    // Concurrency: r1 -> DIV, r2 -> RAND; pointer now at 1.
    set_req(1, 2'd0, 32'hA1, 32'hB1);
    set_req(2, 2'd2, 32'hA2, 32'hB2);
    tick();
    chk("conc_gnt1", req_gnt, 4'b0010);
    chk("conc_slv1", slv_vld, 3'b001);
    chk("conc_d0_1", slv_data0, 32'hA1);
    chk("conc_d1_1", slv_data1, 32'hB1);
    req_vld[1] = 1'b0;
    tick();
    chk("conc_gnt2", req_gnt, 4'b0100);
    chk("conc_slv2", slv_vld, 3'b100);
    chk("conc_d0_2", slv_data0, 32'hA2);
    req_vld[2] = 1'b0;
    slv_rsp_vld  = 3'b101;
    slv_rsp_data = {32'h22, 32'h0, 32'h11};
    tick();
    slv_rsp_vld = '0;
    chk("conc_rsp", rsp_vld, 4'b0110);
    chk("conc_rd1", rd(1), 32'h11);
    chk("conc_rd2", rd(2), 32'h22);
    chk("conc_err", rsp_err, 0);
    tick();
    chk("conc_pulse", rsp_vld, 0);

    // Invalid target on r3 (pointer at 3), then on r0 which holds 0x104.
    set_req(3, 2'd3, 32'h5, 32'h6);
    tick();
    chk("inv_gnt", req_gnt, 4'b1000);
    chk("inv_slv", slv_vld, 0);
    chk("inv_early", rsp_vld, 0);
    tick();
    req_vld[3] = 1'b0;
    chk("inv_rsp", rsp_vld, 4'b1000);
    chk("inv_err", rsp_err, 4'b1000);
    chk("inv_rd3", rd(3), 0);
    chk("inv_slv2", slv_vld, 0);
    set_req(0, 2'd3, 32'h7, 32'h8);
    tick();
    chk("inv0_gnt", req_gnt, 4'b0001);
    tick();
    req_vld[0] = 1'b0;
    chk("inv0_rsp", rsp_vld, 4'b0001);
    chk("inv0_err", rsp_err, 4'b1001);
    chk("inv0_rd0", rd(0), 0);
    tick();

    // Single MUL request, 3*5, engine answers 4 cycles after issue.
    set_req(0, 2'd1, 32'd3, 32'd5);
    tick();
    chk("mul_gnt", req_gnt, 4'b0001);
    chk("mul_slv", slv_vld, 3'b010);
    chk("mul_d0", slv_data0, 3);
    chk("mul_d1", slv_data1, 5);
    tick();
    req_vld[0] = 1'b0;
    chk("mul_nogrant", req_gnt, 0);
    tick(); tick(); tick();
    slv_rsp_vld = 3'b010;
    slv_rsp_data[63:32] = 32'd15;
    tick();
    slv_rsp_vld = '0;
    chk("mul_rsp", rsp_vld, 4'b0001);
    chk("mul_rd", rd(0), 15);
    chk("mul_err", rsp_err[0], 0);
    tick();
    chk("mul_pulse", rsp_vld, 0);
    chk("mul_hold", rd(0), 15);

    // Reset while MUL busy; stray response afterwards must be dropped.
    set_req(0, 2'd1, 32'd7, 32'd9);
    tick();
    chk("rmid_gnt", req_gnt, 4'b0001);
    req_vld[0] = 1'b0;
    rst_sync_l = 1'b0;
    #1;
    chk("rmid_gnt0", req_gnt, 0);
    chk("rmid_slv0", slv_vld, 0);
    chk("rmid_d0", slv_data0, 0);
    chk("rmid_rd0", rd(0), 0);
    chk("rmid_rd1", rd(1), 0);
    chk("rmid_err", rsp_err, 0);
    tick(); tick();
    rst_sync_l = 1'b1;
    slv_rsp_vld = 3'b010;
    slv_rsp_data[63:32] = 32'h99;
    tick();
    slv_rsp_vld = '0;
    chk("rmid_stray", rsp_vld, 0);
    chk("rmid_rd0b", rd(0), 0);
    tick();
    chk("rmid_stray2", rsp_vld, 0);

`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
    // DIV never answers: watchdog reply at issue+17.
    set_req(0, 2'd0, 32'd1, 32'd2);
    tick();
    chk("to_gnt", req_gnt, 4'b0001);
    chk("to_slv", slv_vld, 3'b001);
    req_vld[0] = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    chk("to_early", rsp_vld, 0);
    tick();
    chk("to_rsp", rsp_vld, 4'b0001);
    chk("to_err", rsp_err[0], 1);
    chk("to_rd", rd(0), 0);
    slv_rsp_vld = 3'b001;
    slv_rsp_data[31:0] = 32'h55;
    tick();
    slv_rsp_vld = '0;
    chk("to_late", rsp_vld, 0);
    set_req(0, 2'd0, 32'd3, 32'd4);
    tick();
    req_vld[0] = 1'b0;
    chk("to_regnt", req_gnt, 4'b0001);
    chk("to_reslv", slv_vld, 3'b001);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/syn_gpu_mulbry_arb.md
# syn_gpu_mulbry_arb

Round-robin arbiter and scheduler that shares the GPU mulberry engines (divider, multiplier, random generator) between up to NUM_REQ GPU core job requesters. Each engine runs at most one transaction at a time. Engines are tracked independently, so different requesters can keep different engines busy concurrently. Each response is routed back to the requester that owns it. The block sits between the GPU core job logic and the `div_mp`/`mul_mp`/`rand_mp` engine ports inside `syn_gpu`.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- TIMEOUT_CYC, 1024, engine watchdog limit in cycles (used only with the timeout macro)
- clk_ir  in  1  GPU clock
- rst_sync_l  in  1  reset, asynchronous, active-low
- req_vld  in  NUM_REQ  request valid, held until req_gnt
- req_tgt  in  2*NUM_REQ  target per requester: 0=DIV, 1=MUL, 2=RAND, 3=invalid
- req_data0 / req_data1  in  NUM_REQ*DATA_W  operands per requester
- req_gnt  out  NUM_REQ  one-cycle grant pulse
- rsp_vld  out  NUM_REQ  one-cycle response pulse
- rsp_data  out  NUM_REQ*DATA_W  result per requester, held until next rsp_vld
- rsp_err  out  NUM_REQ  error qualifier, valid with rsp_vld
- slv_vld  out  3  one-hot issue strobe to the DIV/MUL/RAND engines
- slv_data0 / slv_data1  out  DATA_W  shared issue operands
- slv_rsp_vld  in  3  engine result strobe
- slv_rsp_data  in  3*DATA_W  engine results

## Operation
- Per-engine state: IDLE / BUSY, with an owner index. Per-requester state: outstanding flag.
- A requester is eligible when:
  - req_vld=1,
  - its outstanding flag is 0, and
  - its target engine is IDLE, or req_tgt=3.
- Each cycle at most one eligible requester wins. The search is round-robin, starting at the pointer rr_ptr.
- On a win:
  - rr_ptr becomes winner+1, modulo NUM_REQ.
  - The winner's outstanding flag is set.
  - For tgt 0..2, the engine goes BUSY with owner = winner.
- Issue (registered): req_gnt[winner], slv_vld[tgt], slv_data0 and slv_data1 are driven the cycle after the win.
- Engines always accept an issue, because the arbiter issues only to IDLE engines.
- Invalid target (3): the request is granted. One cycle after req_gnt, the requester receives rsp_vld=1, rsp_err=1, rsp_data=0. No slv_vld is driven.
- Response: slv_rsp_vld[t] while engine t is BUSY produces the following, registered one cycle later:
  - rsp_vld[owner]=1 and rsp_data[owner]=slv_rsp_data[t],
  - rsp_err=0,
  - engine t goes IDLE and the owner's outstanding flag is cleared.
- Simultaneous responses from different engines go to different owners and are all delivered in the same cycle.
- slv_rsp_vld on an IDLE engine is ignored.
- A response and a new request for the same engine in the same cycle: the engine counts as BUSY for arbitration in that cycle.
- Reset values:
  - all outputs 0,
  - rr_ptr=0,
  - all engines IDLE,
  - all outstanding flags 0.
- Reset mid-operation discards in-flight state. Engine results that arrive after reset are ignored.

## Timing
- req_vld sampled at cycle N, requester eligible → req_gnt and slv_vld in cycle N+1.
- The requester drops req_vld, or presents a new request, no earlier than N+2. Its outstanding flag blocks regrant in the meantime.
- slv_rsp_vld in cycle M → rsp_vld in M+1.
- The same engine can be reissued at the earliest in M+2 (arbitration in M+1).
- Issue throughput: one grant per cycle across all engines.

## Configuration
- Macro: SYN_GPU_MULBRY_ARB_TIMEOUT_EN.
- Defined:
  - Each engine has a cycle counter, cleared on issue and incremented while BUSY.
  - When the counter reaches TIMEOUT_CYC, the engine goes IDLE and the owner receives rsp_vld=1, rsp_err=1, rsp_data=0 on the next cycle.
  - A late response from that engine is ignored.
  - If slv_rsp_vld arrives in the same cycle as the timeout, the genuine response wins.
- Undefined: no counters are built, TIMEOUT_CYC is unused, and rsp_err asserts only for target 3.

## Structure
- Shared package `syn_gpu_pkg` holds:
  - the target enum (DIV/MUL/RAND/INV), 2 bits,
  - the engine-count constant (3),
  - the engine state enum (IDLE/BUSY).
- One sub-module, `syn_rr_arb`: a parameterised round-robin picker (request vector plus pointer in, one-hot grant and valid out), purely combinational, reusable elsewhere.

## Test plan
- Single request: requester 0, tgt=MUL, operands 3 and 5; engine answers 15 after 4 cycles.
  - req_gnt[0] and slv_vld[1] at N+1.
  - rsp_vld[0] with rsp_data=15 and rsp_err=0 one cycle after slv_rsp_vld.
- Fairness: requesters 0..3 all request DIV continuously; each DIV takes 2 cycles.
  - Grants are served in order 0,1,2,3,0.
  - A DIV issue never occurs while DIV is BUSY.
- Concurrency: requester 1 requests DIV, requester 2 requests RAND in the same cycle.
  - Grants land in consecutive cycles.
  - Both engines are BUSY together.
  - Same-cycle responses yield rsp_vld[1] and rsp_vld[2] together, each with the correct data.
- Invalid target: requester 3, tgt=3.
  - Grant, then one cycle later rsp_err=1 and rsp_data=0.
  - No slv_vld.
- Reset mid-operation: assert rst_sync_l low while MUL is BUSY, release it, then pulse slv_rsp_vld[1].
  - All outputs are 0 during and after reset.
  - The stray response produces no rsp_vld.
- Timeout (macro defined, TIMEOUT_CYC=16): DIV never responds.
  - rsp_vld with rsp_err=1 at issue+17.
  - A later slv_rsp_vld[0] is ignored.
  - DIV can be reissued.
